// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded RV32I fields into words and streams them to instruction memory.
module instr_encoder_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err_fmt,
    output logic              err_align
);
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;
    state_t state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0] issued;
    logic accept, legal, bj, last;
    logic [31:0] enc;
    assign in_ready = (state == RUN) && (!out_valid || out_ready) && !start;
    assign accept   = in_valid && in_ready;
    assign legal    = (fmt != 3'b100) && (fmt != 3'b111);
    assign bj       = (fmt == 3'b101) || (fmt == 3'b110);
    assign last     = issued == CW'(DEPTH - 1);
    // B/J layouts never carry imm[0]; a set bit 0 is flagged, not encoded
    assign enc = fmt == 3'b011 ? {funct7, rs2, rs1, funct3, rd, opcode} :
                 fmt == 3'b000 ? {imm[11:0], rs1, funct3, rd, opcode} :
                 fmt == 3'b001 ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
                 fmt == 3'b010 ? {imm[31:12], rd, opcode} :
                 fmt == 3'b101 ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
                                 {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
    always_comb begin
        state_next = state;
        if (start)
            state_next = RUN;
        else if (state == RUN && accept && last)
            state_next = FULL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= BASE_ADDR;
            issued    <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
            done      <= 1'b0;
            err_fmt   <= 1'b0;
            err_align <= 1'b0;
        end else if (start) begin
            addr      <= BASE_ADDR;
            issued    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err_fmt   <= 1'b0;
            err_align <= 1'b0;
        end else begin
            if (accept) begin
                issued <= issued + 1'b1;
                if (!legal)
                    err_fmt <= 1'b1;
                if (bj && imm[0])
                    err_align <= 1'b1;
            end
            if (accept && legal) begin
                out_valid <= 1'b1;
                out_instr <= enc;
                out_addr  <= addr;
                addr      <= addr + ADDR_W'(4);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            done <= (state == FULL) && !out_valid;
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: scoreboard bench with a field-level reference encoder.
module tb_instr_encoder_loader;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [2:0]  f;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fld_t;

    logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, done, err_fmt, err_align;
    logic [2:0] fmt = 0, funct3 = 0;
    logic [6:0] opcode = 0, funct7 = 0;
    logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
    logic [31:0] imm = 0, out_instr, out_addr;

    int total = 0, passed = 0;
    logic [63:0] q[$];
    bit m_run = 0, m_efmt = 0, m_ealign = 0;
    int m_cnt = 0;
    logic [31:0] m_addr = BASE;
    bit hold = 0;
    logic [63:0] hv;

    instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .done(done), .err_fmt(err_fmt),
        .err_align(err_align)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    endtask

    // Field placement by shifts and masks, straight from the RV32I layouts
    function automatic logic [31:0] encode(input fld_t b);
        logic [31:0] op, rdv, f3, r1, r2, f7, im;
        op = 32'(b.op); rdv = 32'(b.rd); f3 = 32'(b.f3);
        r1 = 32'(b.rs1); r2 = 32'(b.rs2); f7 = 32'(b.f7); im = b.imm;
        case (b.f)
            3'b011:  return op | rdv << 7 | f3 << 12 | r1 << 15 | r2 << 20 | f7 << 25;
            3'b000:  return op | rdv << 7 | f3 << 12 | r1 << 15 | (im & 32'hFFF) << 20;
            3'b001:  return op | (im & 31) << 7 | f3 << 12 | r1 << 15 | r2 << 20 | ((im >> 5) & 127) << 25;
            3'b010:  return op | rdv << 7 | (im & 32'hFFFF_F000);
            3'b101:  return op | ((im >> 11) & 1) << 7 | ((im >> 1) & 15) << 8 | f3 << 12 | r1 << 15
                            | r2 << 20 | ((im >> 5) & 63) << 25 | ((im >> 12) & 1) << 31;
            default: return op | rdv << 7 | (im & 32'h000F_F000) | ((im >> 11) & 1) << 20
                            | ((im >> 1) & 1023) << 21 | ((im >> 20) & 1) << 31;
        endcase
    endfunction

    task automatic step(input bit st, input bit v, input bit ordy, input fld_t b,
                        input bit use_lit, input logic [31:0] lit);
        bit exp_rdy;
        @(posedge clk); #1;
        start = st; in_valid = v; out_ready = ordy;
        fmt = b.f; opcode = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
        funct3 = b.f3; funct7 = b.f7; imm = b.imm;
        @(negedge clk); #1;
        exp_rdy = m_run && !st && (ordy || q.size() == 0);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("err_fmt", 64'(err_fmt), 64'(m_efmt));
        chk("err_align", 64'(err_align), 64'(m_ealign));
        if (st) begin
            q.delete(); m_addr = BASE; m_cnt = 0; m_efmt = 0; m_ealign = 0; m_run = 1;
        end else if (v && exp_rdy) begin
            m_cnt++;
            if (m_cnt == DEPTH) m_run = 0;
            if (b.f == 3'b100 || b.f == 3'b111) m_efmt = 1;
            else begin
                q.push_back({use_lit ? lit : encode(b), m_addr});
                m_addr += 4;
            end
            if ((b.f == 3'b101 || b.f == 3'b110) && b.imm[0]) m_ealign = 1;
        end
    endtask

    task automatic ins(input fld_t b, input logic [31:0] lit);
        step(0, 1, 1, b, 1, lit);
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, ordy, '0, 0, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_instr", 64'(out_instr), 0);
        chk("rst_out_addr", 64'(out_addr), 64'(BASE));
        chk("rst_flags", {61'b0, done, err_fmt, err_align}, 0);
    endtask

    function automatic fld_t rnd_fld();
        fld_t b;
        logic [2:0] fl[8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b100, 3'b111};
        b.f = fl[$urandom_range(0, 7) == 0 ? $urandom_range(6, 7) : $urandom_range(0, 5)];
        b.op = 7'($urandom); b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
        b.f3 = 3'($urandom); b.f7 = 7'($urandom); b.imm = $urandom;
        return b;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) hold = 0;
        else begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (hold) chk("hold_stable", {out_instr, out_addr}, hv);
            hold = out_valid && !out_ready && !start;
            hv = {out_instr, out_addr};
            if (out_valid && out_ready && !start && q.size() != 0)
                chk("word", {out_instr, out_addr}, q.pop_front());
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_reset_vals();
        rst_n = 1;
        @(negedge clk); #1 chk_reset_vals();
        step(0, 1, 1, '{3'b011, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0}, 0, 0);

        // R, I, S, U program; address wraps past 2^32
        step(1, 0, 1, '0, 0, 0);
        ins('{3'b011, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'd0}, 32'h403100B3);
        ins('{3'b000, 7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF}, 32'hFFF00293);
        ins('{3'b001, 7'b0100011, 5'd0, 5'd2, 5'd6, 3'd2, 7'd0, 32'd8}, 32'h00612423);
        ins('{3'b010, 7'b0110111, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000}, 32'h123453B7);
        idle(1); chk("done_early", 64'(done), 0);
        idle(1); idle(1); chk("done", 64'(done), 1);
        step(0, 1, 1, rnd_fld(), 0, 0);

        // B/J, misaligned B, illegal fmt
        step(1, 0, 1, '0, 0, 0);
        ins('{3'b101, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC}, 32'hFE208EE3);
        ins('{3'b110, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048}, 32'h001000EF);
        step(0, 1, 1, '{3'b101, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3}, 0, 0);
        step(0, 1, 1, '{3'b100, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0}, 0, 0);
        idle(1); idle(1); idle(1); chk("done_bj", 64'(done), 1);

        // backpressure: word held five cycles, no new accepts
        step(1, 0, 1, '0, 0, 0);
        step(0, 1, 0, rnd_fld(), 0, 0);
        repeat (5) step(0, 1, 0, rnd_fld(), 0, 0);
        step(0, 1, 1, rnd_fld(), 0, 0);
        idle(1);

        // start while stalled drops the word; next one lands at BASE
        step(1, 0, 1, '0, 0, 0);
        step(0, 1, 0, '{3'b011, 7'h33, 5'd4, 5'd5, 5'd6, 3'd1, 7'd0, 32'd0}, 0, 0);
        idle(0); idle(0);
        step(1, 0, 1, '0, 0, 0);
        ins('{3'b000, 7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF}, 32'hFFF00293);
        idle(1);

        for (int i = 0; i < 400; i++) begin
            bit st;
            st = ($urandom_range(0, 39) == 0) || (!m_run && $urandom_range(0, 3) == 0);
            step(st, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rnd_fld(), 0, 0);
            if (i == 200) begin
                step(1, 0, 1, '0, 0, 0);
                step(0, 1, 0, rnd_fld(), 0, 0);
                @(posedge clk); #2 rst_n = 0;
                #1 chk_reset_vals();
                q.delete(); m_run = 0; m_cnt = 0; m_efmt = 0; m_ealign = 0; m_addr = BASE;
                start = 0; in_valid = 0;
                @(posedge clk); #1 rst_n = 1;
                step(0, 1, 1, rnd_fld(), 0, 0);
            end
        end
        repeat (4) idle(1);
        chk("drained", 64'(q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
